// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: shared sizing helper, parity constant and shift-direction type
// for serial_frame_shifter.
package serial_frame_pkg;
    // Required XOR of data bits and parity bit for even parity.
    localparam logic PARITY_EVEN = 1'b0;
    typedef enum logic {LSB_FIRST, MSB_FIRST} shift_dir_t;
    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction
endpackage

// File: rtl/serial_bit_counter.sv
// serial_bit_counter: modulo-N up-counter with async reset, sync clear,
// enable and a combinational terminal-count pulse on the wrapping strobe.
module serial_bit_counter #(
    parameter int N = 9,
    parameter int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;
    assign o_cnt = r_cnt;
    assign o_tc  = i_en && (r_cnt == W'(N - 1));
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/serial_frame_shifter.sv
// serial_frame_shifter: full-duplex framed shift register with rx holding register
// and valid/ready handshake; SERIAL_FRAME_SHIFTER_PARITY_EN adds an even-parity slot.
module serial_frame_shifter #(
    parameter int WIDTH     = 9,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             sin,
    output logic             sout,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ack,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun,
    output logic             busy,
`ifdef SERIAL_FRAME_SHIFTER_PARITY_EN
    output logic             parity_err,
    output logic [serial_frame_pkg::cnt_w(WIDTH)-1:0] bit_cnt
`else
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
`endif
);
    import serial_frame_pkg::*;
`ifdef SERIAL_FRAME_SHIFTER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    logic [WIDTH-1:0] r_shreg, r_rx_data, w_shifted, w_rx_cand;
    logic             r_rx_valid, r_overrun, r_load_ack;
    logic             w_idle, w_load_acc, w_step, w_tc, w_data_slot, w_store, w_sout_data;

    serial_bit_counter #(.N(FRAME), .W($bits(bit_cnt))) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clr),
        .i_en  (w_step),
        .o_cnt (bit_cnt),
        .o_tc  (w_tc)
    );

    assign w_idle      = bit_cnt == '0;
    assign w_load_acc  = load && w_idle;
    // A load in IDLE steals the strobe, so en is ignored that cycle.
    assign w_step      = en && !w_load_acc;
    assign w_shifted   = MSB_FIRST ? {r_shreg[WIDTH-2:0], sin} : {sin, r_shreg[WIDTH-1:1]};
    assign w_sout_data = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_store     = w_tc && (!r_rx_valid || rx_ready);
    assign busy        = !w_idle;
    assign load_ack    = r_load_ack;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign overrun     = r_overrun;

`ifdef SERIAL_FRAME_SHIFTER_PARITY_EN
    logic r_tx_par, r_parity_err;
    // The parity slot carries no data, so the shifter holds the completed frame.
    assign w_data_slot = int'(bit_cnt) != WIDTH;
    assign w_rx_cand   = r_shreg;
    assign sout        = w_data_slot ? w_sout_data : r_tx_par;
    assign parity_err  = r_parity_err;
    always_ff @(posedge clk or posedge rst)
        if (rst) {r_tx_par, r_parity_err} <= '0;
        else if (clr) {r_tx_par, r_parity_err} <= '0;
        else begin
            if (w_load_acc) r_tx_par <= ^load_data;
            if (w_store) r_parity_err <= (^r_shreg ^ sin) != PARITY_EVEN;
        end
`else
    assign w_data_slot = 1'b1;
    assign w_rx_cand   = w_shifted;
    assign sout        = w_sout_data;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) {r_shreg, r_rx_data, r_rx_valid, r_overrun, r_load_ack} <= '0;
        else if (clr) {r_shreg, r_rx_data, r_rx_valid, r_overrun, r_load_ack} <= '0;
        else begin
            r_load_ack <= w_load_acc;
            if (w_load_acc) r_shreg <= load_data;
            else if (w_step && w_data_slot) r_shreg <= w_shifted;
            if (w_store) r_rx_data <= w_rx_cand;
            r_rx_valid <= w_store || (r_rx_valid && !rx_ready);
            r_overrun  <= r_overrun || (w_tc && r_rx_valid && !rx_ready);
        end
endmodule
